ad_jesd204_rx_lane_deskew: RTL and testbench
============================================

AD_JESD204_RX_LANE_DESKEW -- requirements
Module: ad_jesd204_rx_lane_deskew

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1, number of 32-bit lanes (1..8).
REQ-002 SHALL have parameter DEPTH, default 8, per-lane buffer depth in 32-bit words (power of 2, 4..32).
REQ-003 SHALL have port rx_clk  input  1  single clock, line-rate/40; all logic on rising edge.
REQ-004 SHALL have port rx_resetn  input  1  reset, synchronous to rx_clk, active-low.
REQ-005 SHALL have port cfg_enable  input  1  1 = align and run, 0 = hold in IDLE and flush.
REQ-006 SHALL have port in_data  input  NUM_LANES*32  per-lane link data, lane n at [n*32+:32].
REQ-007 SHALL have port in_valid  input  NUM_LANES  per-lane word valid.
REQ-008 SHALL have port in_mf_start  input  NUM_LANES  per-lane marker: this word starts a multiframe.
REQ-009 SHALL have port in_sof  input  4  start-of-frame octet flags of lane 0, qualified by in_valid[0].
REQ-010 SHALL have port lmfc_release  input  1  single-cycle release opportunity pulse.
REQ-011 SHALL have port rx_data  output  NUM_LANES*32  deskewed data to the ADC interface stage.
REQ-012 SHALL have port rx_sof  output  4  sof flags travelling with lane 0 word of rx_data.
REQ-013 SHALL have port rx_valid  output  1  rx_data/rx_sof valid.
REQ-014 SHALL have port status_aligned  output  1  1 while in RUN.
REQ-015 SHALL have port status_lane_locked  output  NUM_LANES  lane has captured its marker.
REQ-016 SHALL have port status_err  output  1  sticky overflow/underflow flag.

Function
REQ-017 SHALL implement one FIFO per lane, DEPTH words of {data, sof(lane 0 only)}, write/read pointers log2(DEPTH)+1 bits, wrap-around modulo 2*DEPTH, full = MSBs differ and LSBs equal, empty = pointers equal.
REQ-018 SHALL implement states IDLE, ALIGN, WAIT_RELEASE, RUN.
REQ-019 IDLE: all FIFOs flushed, lane locks cleared; cfg_enable=1 -> ALIGN next cycle.
REQ-020 ALIGN: per lane, words with in_valid=1 and in_mf_start=0 discarded while unlocked; first word with in_valid=1 and in_mf_start=1 written and lane locked; subsequent valid words written.
REQ-021 ALIGN -> WAIT_RELEASE in the cycle after all lanes are locked.
REQ-022 WAIT_RELEASE: writes continue; lmfc_release=1 -> RUN next cycle; release pulse seen in ALIGN ignored.
REQ-023 RUN: all lanes read in lockstep every cycle; rx_data/rx_sof registered from FIFO heads, rx_valid=1 one cycle after the read; marker word of every lane appears on rx_data in the same cycle.
REQ-024 Latency in RUN from first read to rx_valid = 1 cycle; lane skew absorbed up to DEPTH-1 words.
REQ-025 Write to a full FIFO in any state: word dropped, status_err set, state -> IDLE next cycle (re-align from flush).
REQ-026 RUN with any FIFO empty at read: no read on any lane, rx_valid=0, status_err set, state -> IDLE next cycle.
REQ-027 Simultaneous write and read on same FIFO in same cycle SHALL both take effect; occupancy unchanged.
REQ-028 cfg_enable=0 in any state -> IDLE next cycle, FIFOs flushed, rx_valid=0; status_err cleared only while cfg_enable=0.
REQ-029 Outside RUN, rx_valid=0 and rx_data/rx_sof hold last value.
REQ-030 status_aligned = (state==RUN), registered; status_lane_locked registered per lane.

Reset
REQ-031 rx_resetn=0 at a rising edge SHALL force state IDLE, pointers 0, locks 0, rx_data 0, rx_sof 0, rx_valid 0, status_aligned 0, status_lane_locked 0, status_err 0.
REQ-032 Reset mid-RUN SHALL take effect at the next edge; buffered data discarded, no rx_valid pulse after.

Verification
REQ-033 NUM_LANES=4, DEPTH=8, markers at lane skews 0/1/3/5 cycles, release 2 cycles after last lock -> rx_valid rises 2 cycles after release, all four marker words on rx_data in the same cycle.
REQ-034 Skew 8 words on one lane with DEPTH=8 -> lane 0 FIFO full, status_err=1, state IDLE, then re-align succeeds after cfg_enable toggle with skew reduced to 2.
REQ-035 In RUN, drop in_valid[2] for 1 cycle with zero slack -> rx_valid=0, status_err=1, status_aligned=0 next cycle.
REQ-036 lmfc_release pulsed during ALIGN only -> stays in WAIT_RELEASE after locks, no rx_valid until next pulse.
REQ-037 rx_resetn=0 for 1 cycle during RUN -> all outputs 0 next cycle; with cfg_enable=1 re-enters ALIGN following cycle.
REQ-038 in_sof=4'b0001 on lane 0 marker word -> rx_sof=4'b0001 in the same cycle that marker appears on rx_data[31:0].

Source files
------------

// File: rtl/ad_jesd204_rx_lane_deskew.sv
// ---------------------------------------------------------------------------
// ad_jesd204_rx_lane_deskew
//
// Purpose:
//   Aligns up to NUM_LANES JESD204 receive lanes to a common multiframe
//   boundary. Each lane owns a small elastic FIFO. While aligning, a lane
//   discards words until its multiframe-start marker shows up, then buffers
//   everything from the marker onwards. Once every lane holds its marker,
//   the block waits for an LMFC release pulse. After that, all FIFOs are
//   popped in lockstep, so the marker words of all lanes leave together.
//
// Ports:
//   rx_clk             : single clock, all logic on the rising edge
//   rx_resetn          : synchronous active-low reset
//   cfg_enable         : 1 = align and run, 0 = hold in IDLE and flush
//   in_data            : per-lane link data, lane n at [n*32+:32]
//   in_valid           : per-lane word valid
//   in_mf_start        : per-lane marker, word starts a multiframe
//   in_sof             : start-of-frame octet flags of lane 0
//   lmfc_release       : single-cycle release opportunity pulse
//   rx_data            : deskewed data, all lanes
//   rx_sof             : sof flags that travel with the lane 0 word
//   rx_valid           : rx_data/rx_sof valid
//   status_aligned     : 1 while in RUN
//   status_lane_locked : lane has captured its marker
//   status_err         : sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module ad_jesd204_rx_lane_deskew #(
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                    rx_clk,
    input  logic                    rx_resetn,
    input  logic                    cfg_enable,
    input  logic [NUM_LANES*32-1:0] in_data,
    input  logic [NUM_LANES-1:0]    in_valid,
    input  logic [NUM_LANES-1:0]    in_mf_start,
    input  logic [3:0]              in_sof,
    input  logic                    lmfc_release,
    output logic [NUM_LANES*32-1:0] rx_data,
    output logic [3:0]              rx_sof,
    output logic                    rx_valid,
    output logic                    status_aligned,
    output logic [NUM_LANES-1:0]    status_lane_locked,
    output logic                    status_err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_ALIGN        = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN          = 2'd3;

    // Storage and state
    logic [31:0]             r_mem     [NUM_LANES][DEPTH];
    logic [3:0]              r_sof_mem [DEPTH];
    logic [AW:0]             r_wr_ptr  [NUM_LANES];
    logic [AW:0]             r_rd_ptr  [NUM_LANES];
    logic [NUM_LANES-1:0]    r_locked;
    logic [1:0]              r_state;
    logic [NUM_LANES*32-1:0] r_rx_data;
    logic [3:0]              r_rx_sof;
    logic                    r_rx_valid;
    logic                    r_aligned;
    logic                    r_err;

    // Combinational decode
    logic [1:0]              w_state_nxt;
    logic [NUM_LANES-1:0]    w_full;
    logic [NUM_LANES-1:0]    w_empty;
    logic [NUM_LANES-1:0]    w_wr_req;
    logic [NUM_LANES-1:0]    w_wr_en;
    logic [NUM_LANES-1:0]    w_ovf_lane;
    logic [NUM_LANES-1:0]    w_lock_set;
    logic [NUM_LANES*32-1:0] w_head_data;
    logic [3:0]              w_head_sof;
    logic                    w_rd_en;
    logic                    w_underflow;
    logic                    w_overflow;
    logic                    w_flush;
    logic                    w_all_locked;

    // -----------------------------------------------------------------------
    // FIFO status and head words
    // -----------------------------------------------------------------------
    always_comb begin
        w_full      = '0;
        w_empty     = '0;
        w_head_data = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            w_empty[n] = (r_wr_ptr[n] == r_rd_ptr[n]);
            // Full: same slot index, but the writer is one lap ahead.
            w_full[n]  = (r_wr_ptr[n][AW] != r_rd_ptr[n][AW]) &&
                         (r_wr_ptr[n][AW-1:0] == r_rd_ptr[n][AW-1:0]);
            w_head_data[n*32 +: 32] = r_mem[n][r_rd_ptr[n][AW-1:0]];
        end
    end

    assign w_head_sof   = r_sof_mem[r_rd_ptr[0][AW-1:0]];
    assign w_all_locked = &r_locked;

    // Lanes are only ever read together; one empty lane stalls all of them.
    assign w_rd_en     = cfg_enable && (r_state == ST_RUN) && !(|w_empty);
    assign w_underflow = cfg_enable && (r_state == ST_RUN) && (|w_empty);

    // -----------------------------------------------------------------------
    // Write side: marker capture and overflow detection
    // -----------------------------------------------------------------------
    always_comb begin
        w_wr_req   = '0;
        w_wr_en    = '0;
        w_ovf_lane = '0;
        w_lock_set = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            w_lock_set[n] = cfg_enable && (r_state == ST_ALIGN) &&
                            in_valid[n] && in_mf_start[n];
            // Unlocked lanes drop everything until their marker arrives; the
            // marker word itself is the first one stored.
            w_wr_req[n]   = cfg_enable && (r_state != ST_IDLE) && in_valid[n] &&
                            (r_locked[n] || w_lock_set[n]);
            // A same-cycle read frees the slot, so a full FIFO only overflows
            // when nothing is being popped.
            w_ovf_lane[n] = w_wr_req[n] && w_full[n] && !w_rd_en;
            w_wr_en[n]    = w_wr_req[n] && !w_ovf_lane[n];
        end
    end

    assign w_overflow = |w_ovf_lane;

    // Any route back to IDLE discards buffered data and locks immediately.
    assign w_flush = !cfg_enable || (r_state == ST_IDLE) || w_overflow || w_underflow;

    // -----------------------------------------------------------------------
    // State machine next-state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!cfg_enable || w_overflow || w_underflow) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ALIGN;
                end
                ST_ALIGN: begin
                    // Release pulses are ignored here by construction.
                    if (w_all_locked) begin
                        w_state_nxt = ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (lmfc_release) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage (no reset needed, pointers qualify the contents)
    // -----------------------------------------------------------------------
    always_ff @(posedge rx_clk) begin
        for (int n = 0; n < NUM_LANES; n++) begin
            if (w_wr_en[n]) begin
                r_mem[n][r_wr_ptr[n][AW-1:0]] <= in_data[n*32 +: 32];
            end
        end
        if (w_wr_en[0]) begin
            r_sof_mem[r_wr_ptr[0][AW-1:0]] <= in_sof;
        end
    end

    // -----------------------------------------------------------------------
    // Control state, pointers and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge rx_clk) begin
        if (!rx_resetn) begin
            r_state    <= ST_IDLE;
            r_locked   <= '0;
            r_rx_data  <= '0;
            r_rx_sof   <= '0;
            r_rx_valid <= 1'b0;
            r_aligned  <= 1'b0;
            r_err      <= 1'b0;
            for (int n = 0; n < NUM_LANES; n++) begin
                r_wr_ptr[n] <= '0;
                r_rd_ptr[n] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_aligned  <= (w_state_nxt == ST_RUN);
            r_rx_valid <= w_rd_en;

            // Output data holds its last value whenever nothing is read.
            if (w_rd_en) begin
                r_rx_data <= w_head_data;
                r_rx_sof  <= w_head_sof;
            end

            // Sticky error; only a disabled block can clear it.
            if (!cfg_enable) begin
                r_err <= 1'b0;
            end else if (w_overflow || w_underflow) begin
                r_err <= 1'b1;
            end

            for (int n = 0; n < NUM_LANES; n++) begin
                if (w_flush) begin
                    r_wr_ptr[n] <= '0;
                    r_rd_ptr[n] <= '0;
                    r_locked[n] <= 1'b0;
                end else begin
                    if (w_wr_en[n]) begin
                        r_wr_ptr[n] <= r_wr_ptr[n] + PTR_ONE;
                    end
                    if (w_rd_en) begin
                        r_rd_ptr[n] <= r_rd_ptr[n] + PTR_ONE;
                    end
                    if (w_lock_set[n]) begin
                        r_locked[n] <= 1'b1;
                    end
                end
            end
        end
    end

    assign rx_data            = r_rx_data;
    assign rx_sof             = r_rx_sof;
    assign rx_valid           = r_rx_valid;
    assign status_aligned     = r_aligned;
    assign status_lane_locked = r_locked;
    assign status_err         = r_err;

endmodule

// File: tb/tb_ad_jesd204_rx_lane_deskew.sv
// ---------------------------------------------------------------------------
// tb_ad_jesd204_rx_lane_deskew
//
// Directed scenarios plus a randomized phase for the lane deskew block with
// four lanes and 8-word FIFOs. A queue-based reference model predicts every
// output after every clock edge.
// ---------------------------------------------------------------------------
module tb_ad_jesd204_rx_lane_deskew;

    localparam int NL = 4;
    localparam int DP = 8;

    typedef logic [NL*32-1:0] word_t;
    typedef enum int {MIdle, MAlign, MWait, MRun} mode_t;

    logic          rx_clk = 1'b0;
    logic          rx_resetn;
    logic          cfg_enable;
    word_t         in_data;
    logic [NL-1:0] in_valid;
    logic [NL-1:0] in_mf_start;
    logic [3:0]    in_sof;
    logic          lmfc_release;
    word_t         rx_data;
    logic [3:0]    rx_sof;
    logic          rx_valid;
    logic          status_aligned;
    logic [NL-1:0] status_lane_locked;
    logic          status_err;

    int    checks   = 0;
    int    failures = 0;
    string g_phase  = "init";

    ad_jesd204_rx_lane_deskew #(
        .NUM_LANES (NL),
        .DEPTH     (DP)
    ) dut (
        .rx_clk             (rx_clk),
        .rx_resetn          (rx_resetn),
        .cfg_enable         (cfg_enable),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_mf_start        (in_mf_start),
        .in_sof             (in_sof),
        .lmfc_release       (lmfc_release),
        .rx_data            (rx_data),
        .rx_sof             (rx_sof),
        .rx_valid           (rx_valid),
        .status_aligned     (status_aligned),
        .status_lane_locked (status_lane_locked),
        .status_err         (status_err)
    );

    always #5 rx_clk = ~rx_clk;

    // ----------------------------------------------------------------------
    // Reference model: one queue per lane, entries are {sof, data}
    // ----------------------------------------------------------------------
    mode_t         m_mode;
    logic [35:0]   m_q [NL][$];
    logic [NL-1:0] m_locked;
    word_t         e_data;
    logic [3:0]    e_sof;
    logic          e_valid;
    logic          e_aligned;
    logic          e_err;

    task automatic m_flush();
        for (int n = 0; n < NL; n++) m_q[n].delete();
        m_locked = '0;
    endtask

    task automatic model_step();
        bit            rd;
        bit            err_now;
        bit            all_locked_before;
        logic [35:0]   w;
        if (!rx_resetn) begin
            m_mode = MIdle;
            m_flush();
            e_data = '0; e_sof = '0; e_valid = 0; e_aligned = 0; e_err = 0;
            return;
        end
        if (!cfg_enable) begin
            m_mode = MIdle;
            m_flush();
            e_valid = 0; e_aligned = 0; e_err = 0;
            return;
        end
        // Lockstep read: only when every lane has something.
        rd = (m_mode == MRun);
        for (int n = 0; n < NL; n++) if (m_q[n].size() == 0) rd = 0;
        err_now = (m_mode == MRun) && !rd;
        if (rd) begin
            for (int n = 0; n < NL; n++) begin
                w = m_q[n].pop_front();
                e_data[n*32 +: 32] = w[31:0];
                if (n == 0) e_sof = w[35:32];
            end
        end
        e_valid = rd;
        all_locked_before = (m_locked == '1);
        if (m_mode != MIdle) begin
            for (int n = 0; n < NL; n++) begin
                if (in_valid[n] && (m_locked[n] || (m_mode == MAlign && in_mf_start[n]))) begin
                    if (m_q[n].size() >= DP) err_now = 1;
                    else m_q[n].push_back({(n == 0) ? in_sof : 4'h0, in_data[n*32 +: 32]});
                end
                if (m_mode == MAlign && in_valid[n] && in_mf_start[n]) m_locked[n] = 1'b1;
            end
        end
        if (err_now) begin
            e_err  = 1;
            m_mode = MIdle;
            m_flush();
        end else begin
            case (m_mode)
                MIdle:  m_mode = MAlign;
                MAlign: if (all_locked_before) m_mode = MWait;
                MWait:  if (lmfc_release) m_mode = MRun;
                default: m_mode = MRun;
            endcase
        end
        e_aligned = (m_mode == MRun);
    endtask

    // ----------------------------------------------------------------------
    // Stimulus and checking helpers
    // ----------------------------------------------------------------------
    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s [%s]: observed %0h, expected %0h", tag, g_phase, obs, exp);
        end
    endtask

    task automatic drive(input logic [NL-1:0] v, input logic [NL-1:0] mf,
                         input logic [3:0] sof, input logic rel);
        in_valid     = v;
        in_mf_start  = mf;
        in_sof       = sof;
        lmfc_release = rel;
        for (int n = 0; n < NL; n++) in_data[n*32 +: 32] = $urandom;
    endtask

    task automatic step();
        model_step();
        @(posedge rx_clk);
        #1;
        chk("rx_valid", word_t'(rx_valid), word_t'(e_valid));
        chk("rx_data", rx_data, e_data);
        chk("rx_sof", word_t'(rx_sof), word_t'(e_sof));
        chk("status_aligned", word_t'(status_aligned), word_t'(e_aligned));
        chk("status_lane_locked", word_t'(status_lane_locked), word_t'(m_locked));
        chk("status_err", word_t'(status_err), word_t'(e_err));
    endtask

    task automatic toggle_enable();
        cfg_enable = 1'b0;
        drive('1, '0, 4'h0, 1'b0);
        step();
        chk("disabled_err_clear", word_t'(status_err), '0);
        cfg_enable = 1'b1;
        drive('1, '0, 4'h0, 1'b0);
        step();
    endtask

    // ----------------------------------------------------------------------
    // Directed sequence followed by randomized traffic
    // ----------------------------------------------------------------------
    int          skew [NL];
    logic [31:0] mk   [NL];
    word_t       mk_vec;
    int          rdly;
    logic [NL-1:0] mf;

    initial begin
        m_mode = MIdle;
        m_flush();
        e_data = '0; e_sof = '0; e_valid = 0; e_aligned = 0; e_err = 0;

        // Reset
        g_phase    = "reset";
        rx_resetn  = 1'b0;
        cfg_enable = 1'b0;
        drive('0, '0, 4'h0, 1'b0);
        step();
        step();
        chk("reset_rx_valid", word_t'(rx_valid), '0);
        chk("reset_rx_data", rx_data, '0);
        chk("reset_locked", word_t'(status_lane_locked), '0);
        rx_resetn = 1'b1;

        // Skews 0/1/3/5, release two cycles after the last marker
        g_phase    = "skew0135";
        skew       = '{0, 1, 3, 5};
        cfg_enable = 1'b1;
        drive('1, '0, 4'h0, 1'b0);
        step();                              // IDLE -> ALIGN
        drive('1, '0, 4'h2, 1'b0);
        step();                              // pre-marker words are discarded
        for (int c = 0; c < 6; c++) begin
            mf = '0;
            for (int n = 0; n < NL; n++) if (c == skew[n]) mf[n] = 1'b1;
            drive('1, mf, (c == 0) ? 4'b0001 : 4'b0100, 1'b0);
            for (int n = 0; n < NL; n++) if (mf[n]) mk[n] = in_data[n*32 +: 32];
            step();
        end
        drive('1, '0, 4'h0, 1'b0);
        step();
        chk("all_locked", word_t'(status_lane_locked), word_t'(4'hf));
        drive('1, '0, 4'h0, 1'b1);
        step();
        chk("release_no_valid_yet", word_t'(rx_valid), '0);
        chk("release_aligned", word_t'(status_aligned), word_t'(1'b1));
        drive('1, '0, 4'h0, 1'b0);
        step();
        for (int n = 0; n < NL; n++) mk_vec[n*32 +: 32] = mk[n];
        chk("first_valid", word_t'(rx_valid), word_t'(1'b1));
        chk("markers_together", rx_data, mk_vec);
        chk("marker_sof", word_t'(rx_sof), word_t'(4'b0001));
        for (int c = 0; c < 6; c++) begin
            drive('1, '0, 4'($urandom_range(0, 15)), 1'b0);
            step();
        end

        // Zero-slack lane 2, then drop its valid for one cycle
        g_phase = "underflow";
        toggle_enable();
        drive('1, '1, 4'h1, 1'b0);
        step();
        drive(4'b1011, '0, 4'h0, 1'b0);
        step();
        drive(4'b1011, '0, 4'h0, 1'b1);
        step();
        drive('1, '0, 4'h0, 1'b0);
        step();
        chk("zs_first_valid", word_t'(rx_valid), word_t'(1'b1));
        drive('1, '0, 4'h0, 1'b0);
        step();
        drive(4'b1011, '0, 4'h0, 1'b0);
        step();
        drive('1, '0, 4'h0, 1'b0);
        step();
        chk("uf_valid", word_t'(rx_valid), '0);
        chk("uf_err", word_t'(status_err), word_t'(1'b1));
        chk("uf_aligned", word_t'(status_aligned), '0);

        // Skew of 8 words overflows lane 0, then realign with skew 2
        g_phase = "overflow";
        toggle_enable();
        drive('1, 4'b0001, 4'h1, 1'b0);
        step();
        for (int c = 1; c < 8; c++) begin
            drive('1, '0, 4'h0, 1'b0);
            step();
        end
        drive('1, 4'b1110, 4'h0, 1'b0);
        step();
        chk("ovf_err", word_t'(status_err), word_t'(1'b1));
        chk("ovf_locks_cleared", word_t'(status_lane_locked), '0);
        g_phase = "realign";
        toggle_enable();
        drive('1, 4'b0001, 4'h1, 1'b0);
        mk[0] = in_data[31:0];
        step();
        drive('1, '0, 4'h0, 1'b0);
        step();
        drive('1, 4'b1110, 4'h0, 1'b0);
        for (int n = 1; n < NL; n++) mk[n] = in_data[n*32 +: 32];
        step();
        drive('1, '0, 4'h0, 1'b0);
        step();
        drive('1, '0, 4'h0, 1'b1);
        step();
        drive('1, '0, 4'h0, 1'b0);
        step();
        for (int n = 0; n < NL; n++) mk_vec[n*32 +: 32] = mk[n];
        chk("realign_valid", word_t'(rx_valid), word_t'(1'b1));
        chk("realign_markers", rx_data, mk_vec);
        chk("realign_err", word_t'(status_err), '0);

        // Release only during ALIGN is ignored
        g_phase = "early_release";
        toggle_enable();
        drive('1, '1, 4'h1, 1'b1);
        step();
        drive('1, '0, 4'h0, 1'b1);
        step();
        for (int c = 0; c < 3; c++) begin
            drive('1, '0, 4'h0, 1'b0);
            step();
            chk("wait_not_aligned", word_t'(status_aligned), '0);
            chk("wait_no_valid", word_t'(rx_valid), '0);
        end
        drive('1, '0, 4'h0, 1'b1);
        step();
        drive('1, '0, 4'h0, 1'b0);
        step();
        chk("late_release_valid", word_t'(rx_valid), word_t'(1'b1));

        // One-cycle reset in RUN
        g_phase   = "reset_in_run";
        rx_resetn = 1'b0;
        drive('1, '0, 4'h0, 1'b0);
        step();
        chk("rst_valid", word_t'(rx_valid), '0);
        chk("rst_data", rx_data, '0);
        chk("rst_sof", word_t'(rx_sof), '0);
        chk("rst_aligned", word_t'(status_aligned), '0);
        rx_resetn = 1'b1;
        drive('1, '0, 4'h0, 1'b0);
        step();                              // IDLE -> ALIGN
        drive('1, '1, 4'h0, 1'b0);
        step();
        chk("rst_realign_locks", word_t'(status_lane_locked), word_t'(4'hf));

        // Randomized alignment and traffic
        for (int it = 0; it < 8; it++) begin
            g_phase = $sformatf("random%0d", it);
            toggle_enable();
            for (int n = 0; n < NL; n++) skew[n] = $urandom_range(0, 3);
            rdly = $urandom_range(0, 2);
            for (int c = 0; c < 4; c++) begin
                mf = '0;
                for (int n = 0; n < NL; n++) if (c == skew[n]) mf[n] = 1'b1;
                drive('1, mf, 4'($urandom_range(0, 15)), 1'b0);
                step();
            end
            for (int c = 0; c <= rdly; c++) begin
                drive('1, '0, 4'($urandom_range(0, 15)), 1'b0);
                step();
            end
            drive('1, '0, 4'($urandom_range(0, 15)), 1'b1);
            step();
            for (int c = 0; c < 40; c++) begin
                logic [NL-1:0] v;
                logic [NL-1:0] m;
                for (int n = 0; n < NL; n++) begin
                    v[n] = ($urandom_range(0, 24) != 0);
                    m[n] = ($urandom_range(0, 7) == 0);
                end
                cfg_enable = ($urandom_range(0, 79) != 0);
                drive(v, m, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
                step();
            end
            cfg_enable = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
